// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Bundle of the two requester handshakes and the shared
//             data-memory command/response bus seen by dmem_arbiter.
//  Modports : slave  - arbiter view (samples requests and mem_rdata, drives
//                      grants, completions, read data, mem command, busy)
//             master - environment view (requesters plus memory read data)
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    // Master 0: CPU load/store path
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_width;
    logic          m0_write;
    logic          m0_gnt;
    logic          m0_done;
    logic [DW-1:0] m0_rdata;

    // Master 1: serial loader / debug master
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_width;
    logic          m1_write;
    logic          m1_gnt;
    logic          m1_done;
    logic [DW-1:0] m1_rdata;

    // Shared memory port
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_width;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_width, m0_write,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_width, m1_write,
        output m1_gnt, m1_done, m1_rdata,
        output mem_addr, mem_wdata, mem_width, mem_write,
        input  mem_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_width, m0_write,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_width, m1_write,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_addr, mem_wdata, mem_width, mem_write,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin two-master arbiter and sequencer for the shared
//             data-memory port. One transaction in flight at a time; each
//             access is a single-cycle command with read data captured a
//             fixed RD_LAT cycles later.
//  Ports    : clk    - system clock
//             rst_n  - synchronous active-low reset
//             bus    - dmem_arbiter_if.slave (requesters + memory bus + busy)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 32,
    parameter int RD_LAT = 1     // 1..4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_cnt_init = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    width_q, width_d;
    logic          write_q, write_d;
    logic          mem_write_q, mem_write_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          busy_q, busy_d;

    logic          w_arb_open;
    logic          w_any_req;
    logic          w_win;

    // The cycle carrying a done pulse is a turnaround cycle: requests are not
    // sampled, so a master sees its completion before the bus can be granted
    // again. This gives the RD_LAT+3 grant-to-grant spacing.
    assign w_arb_open = (state_q == S_IDLE) && !(done0_q || done1_q);
    assign w_any_req  = bus.m0_req || bus.m1_req;
    // Under contention the master that was not granted last wins.
    assign w_win      = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        width_d      = width_q;
        write_d      = write_q;
        mem_write_d  = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (w_arb_open && w_any_req) begin
                    sel_d       = w_win;
                    addr_d      = w_win ? bus.m1_addr  : bus.m0_addr;
                    wdata_d     = w_win ? bus.m1_wdata : bus.m0_wdata;
                    width_d     = w_win ? bus.m1_width : bus.m0_width;
                    write_d     = w_win ? bus.m1_write : bus.m0_write;
                    mem_write_d = w_win ? bus.m1_write : bus.m0_write;
                    gnt0_d      = ~w_win;
                    gnt1_d      = w_win;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                last_grant_d = sel_q;
                cnt_d        = c_cnt_init;
                state_d      = (RD_LAT == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // Entered with RD_LAT-1; leave as the count reaches zero so
                // exactly RD_LAT-1 wait cycles separate ISSUE from RESP.
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!write_q) begin
                    if (sel_q) rdata1_d = bus.mem_rdata;
                    else       rdata0_d = bus.mem_rdata;
                end
                done0_d = ~sel_q;
                done1_d = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            width_q      <= 4'd0;
            write_q      <= 1'b0;
            mem_write_q  <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            width_q      <= width_d;
            write_q      <= write_d;
            mem_write_q  <= mem_write_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    // Command registers hold in IDLE so the downstream read mux stays stable.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_width = width_q;
    assign bus.mem_write = mem_write_q;
    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_done   = done0_q;
    assign bus.m1_done   = done1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter and sequencer for the shared data-memory port (the 11-bit data address bus feeding boot ROM port 2, data RAM and the GPO LED peripheral).
- Master 0 is the CPU load/store path; master 1 is the serial loader/debug master.
- Grants are round-robin, with one outstanding transaction at a time.
- Each access is issued as a single-cycle memory command; read data is captured after a fixed latency.

Parameters:
- AW, 11: data address width (bit AW-1 selects ROM vs RAM at top level; passed through untouched).
- DW, 32: data width.
- RD_LAT, 1: memory read latency in cycles from command cycle to valid mem_rdata (1..4).

Ports:
- clk  in  1  system clock (output of clock_gen).
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- m0_req  in  1  CPU request; held high until m0_gnt.
- m0_addr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_width  in  4  CPU byte-enable mask.
- m0_write  in  1  1 = write, 0 = read.
- m0_gnt  out  1  one-cycle pulse: CPU command issued to memory this cycle.
- m0_done  out  1  one-cycle pulse: CPU transaction complete; m0_rdata valid.
- m0_rdata  out  DW  CPU read data; holds until next m0_done.
- m1_req, m1_addr, m1_wdata, m1_width, m1_write, m1_gnt, m1_done, m1_rdata: identical set for master 1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_width  out  4  memory byte-enable mask.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data (the muxed data_in bus).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: on rst_n=0 at a clk edge, state goes to IDLE, last_grant is set to 1 (so m0 has first priority), and all outputs go to 0, including rdata registers and mem_* outputs. Reset mid-transaction abandons it with no done pulse, and any pending mem_write is deasserted the same edge.

States:
- IDLE: sample requests.
  - If only one req is high, that master wins.
  - If both are high, the winner is the master != last_grant.
  - On a win: latch the winner's addr/wdata/width/write into mem_* registers, set sel, and go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle): mem_* outputs carry the latched command and mem_write equals the latched write bit.
  - gnt[sel] = 1 this cycle; the master drops or changes req after seeing gnt.
  - last_grant <= sel.
  - Next state is WAIT with cnt = RD_LAT-1; if RD_LAT == 1, go directly to RESP.
- WAIT: mem_write = 0 and mem_addr is held. cnt decrements each cycle; go to RESP when cnt == 0.
- RESP (1 cycle):
  - If the command was a read, rdata[sel] <= mem_rdata, sampled at this clock edge.
  - The done[sel] pulse goes high the cycle after (registered), and rdata[sel] is visible in the same cycle as done.
  - Writes get done with rdata unchanged.
  - Next state is IDLE.

Timing and rules:
- Latency, req seen in IDLE at edge E0: gnt is high in cycle E0+1, the write lands at the end of the ISSUE cycle, and done is high in cycle E0+2+RD_LAT.
- Minimum spacing between back-to-back grants is RD_LAT+3 cycles; there is no pipelining.
- mem_write is high for exactly one cycle per write and never during WAIT, RESP or IDLE.
- mem_addr, mem_width and mem_wdata hold their last value in IDLE, with no glitch to 0, so the combinational ROM/RAM read mux stays stable.
- A requester dropping req before its gnt is allowed: if it drops in the IDLE sampling cycle it simply is not picked. Once latched, the transaction completes regardless.
- Simultaneous req after an m0 grant: m1 wins. Strict alternation holds under continuous contention, so starvation is bounded by one transaction.
- Width/address are passed unmodified; no alignment checking is done here.
- gnt and done never pulse for both masters in the same cycle.

Test Plan:
- Reset, then m0 read addr=0x404 with mem model returning 0xDEADBEEF at RD_LAT=1 -> m0_gnt at cycle 1, m0_done at cycle 3, m0_rdata=0xDEADBEEF, m1 outputs 0.
- m1 write addr=0x400, wdata=0x000000A5, width=4'b0001 -> mem_write high exactly 1 cycle with those values, m1_done 2 cycles after m1_gnt, m1_rdata unchanged (0).
- m0_req and m1_req held high continuously for 6 transactions -> grant order m0,m1,m0,m1,m0,m1 and grant spacing of 4 cycles (RD_LAT=1).
- RD_LAT=3, m0 read -> mem_addr stable for 4 cycles from ISSUE, done 4 cycles after gnt, rdata = mem value present at RESP, busy high from ISSUE through RESP.
- Assert rst_n=0 during WAIT of an m1 write -> next cycle state IDLE, mem_write=0, no m1_done; with both requesting after release, m0 wins.
- m0 pulses req for one cycle while in ISSUE of an m1 transaction, then drops it -> no m0 grant issued; bus returns to IDLE with busy=0.
